// File: rtl/sprite_blitter_if.sv
// Sprite blitter bus: control handshake, sprite ROM read port and frame-buffer write port.
// The optional mirror input exists only when BLIT_MIRROR_EN is defined.
interface sprite_blitter_if;
  logic        start;
  logic [7:0]  dst_x;
  logic [7:0]  dst_y;
  logic [1:0]  dir;
  logic        busy;
  logic        done;
  logic [9:0]  spr_x;
  logic [9:0]  spr_y;
  logic [1:0]  spr_dir;
  logic [17:0] spr_pixel;
  logic        fb_we;
  logic [12:0] fb_addr;
  logic [15:0] fb_data;
`ifdef BLIT_MIRROR_EN
  logic        mirror;
`endif

  // Blitter side
  modport master (
    input  start, dst_x, dst_y, dir, spr_pixel,
`ifdef BLIT_MIRROR_EN
    input  mirror,
`endif
    output busy, done, spr_x, spr_y, spr_dir, fb_we, fb_addr, fb_data
  );

  // Game FSM / ROM / frame-buffer side
  modport slave (
    output start, dst_x, dst_y, dir, spr_pixel,
`ifdef BLIT_MIRROR_EN
    output mirror,
`endif
    input  busy, done, spr_x, spr_y, spr_dir, fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/sprite_blitter.sv
// Copies one sprite frame from a 1-cycle-latency sprite ROM into the OLED frame buffer at a
// signed destination, skipping transparent texels and clipping to the screen.
// Optional feature macro: BLIT_MIRROR_EN (adds a latched horizontal-flip input).
module sprite_blitter #(
  parameter int unsigned SPR_W = 20,
  parameter int unsigned SPR_H = 20,
  parameter int unsigned FB_W  = 96,
  parameter int unsigned FB_H  = 64
) (
  input logic             clk,
  input logic             rst_n,
  sprite_blitter_if.master bus
);

  localparam int unsigned CW = $clog2(SPR_W);
  localparam int unsigned RW = $clog2(SPR_H);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]    state, state_next;
  logic          accept;
  logic          last_texel;
  logic [CW-1:0] col, col_next, p1_col;
  logic [RW-1:0] row, row_next, p1_row;
  logic          p1_valid;
  logic          flush_cnt;
  logic [7:0]    dst_x_q, dst_y_q;
  logic [9:0]    spr_x_next;
  logic [9:0]    wx, wy;
  logic          in_bounds;
  logic          write_en;
  logic [12:0]   waddr;
  logic          unused_pixel_bit;
`ifdef BLIT_MIRROR_EN
  logic          mirror_q;
  logic          mirror_sel;
`endif

  assign unused_pixel_bit = bus.spr_pixel[1];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state, texel advance and write-slot address/clip evaluation
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_texel = (col == CW'(SPR_W - 1)) && (row == RW'(SPR_H - 1));
    col_next   = col;
    row_next   = row;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN:   if (last_texel) state_next = S_FLUSH;
      S_FLUSH: if (flush_cnt)  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    if (accept) begin
      col_next = '0;
      row_next = '0;
    end else if (col == CW'(SPR_W - 1)) begin
      col_next = '0;
      row_next = row + RW'(1);
    end else begin
      col_next = col + CW'(1);
    end

`ifdef BLIT_MIRROR_EN
    mirror_sel = accept ? bus.mirror : mirror_q;
    spr_x_next = mirror_sel ? (10'(SPR_W - 1) - 10'(col_next)) : 10'(col_next);
`else
    spr_x_next = 10'(col_next);
`endif

    // Destination is signed; a negative result has bit 9 set and fails the clip
    wx        = {{2{dst_x_q[7]}}, dst_x_q} + 10'(p1_col);
    wy        = {{2{dst_y_q[7]}}, dst_y_q} + 10'(p1_row);
    in_bounds = !wx[9] && (wx < 10'(FB_W)) && !wy[9] && (wy < 10'(FB_H));
    write_en  = p1_valid && !bus.spr_pixel[0] && in_bounds;
    waddr     = 13'(wy) * 13'(FB_W) + 13'(wx);
  end

  // Coordinate issue, ROM-latency pipeline, frame-buffer writes and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col         <= '0;
      row         <= '0;
      p1_col      <= '0;
      p1_row      <= '0;
      p1_valid    <= 1'b0;
      flush_cnt   <= 1'b0;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.spr_x   <= '0;
      bus.spr_y   <= '0;
      bus.spr_dir <= '0;
      bus.fb_we   <= 1'b0;
      bus.fb_addr <= '0;
      bus.fb_data <= '0;
`ifdef BLIT_MIRROR_EN
      mirror_q    <= 1'b0;
`endif
    end else begin
      p1_valid  <= (state == S_RUN);
      p1_col    <= col;
      p1_row    <= row;
      flush_cnt <= (state == S_FLUSH) && !flush_cnt;
      bus.done  <= (state == S_FLUSH) && flush_cnt;
      bus.fb_we <= write_en;
      if (write_en) begin
        bus.fb_addr <= waddr;
        bus.fb_data <= bus.spr_pixel[17:2];
      end
      if (accept) begin
        bus.busy    <= 1'b1;
        dst_x_q     <= bus.dst_x;
        dst_y_q     <= bus.dst_y;
        bus.spr_dir <= bus.dir;
`ifdef BLIT_MIRROR_EN
        mirror_q    <= bus.mirror;
`endif
      end else if ((state == S_FLUSH) && flush_cnt) begin
        bus.busy <= 1'b0;
      end
      if (accept || ((state == S_RUN) && !last_texel)) begin
        col       <= col_next;
        row       <= row_next;
        bus.spr_x <= spr_x_next;
        bus.spr_y <= 10'(row_next);
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: ROM model, frame-buffer write monitor and blit scenarios.
// Define BLIT_MIRROR_EN for both bench and RTL to exercise the horizontal-flip scenario.
module tb_sprite_blitter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  sprite_blitter_if bus ();

  sprite_blitter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;

  // Expected blit context used by the write monitor
  int rom_mode = 0;
  int exp_dx = 0, exp_dy = 0, exp_dir = 0, exp_mirror = 0;

  int writes = 0, bad = 0, done_cnt = 0, max_addr = -1;
  int first_addr = 0, last_addr = 0, first_cyc = 0;
  logic [15:0] first_data, last_data;
  logic [15:0] fb_mem [6144];

  function automatic logic [15:0] enc(input int c, input int r, input int d);
    return {2'(d), 4'd0, 5'(r), 5'(c)};
  endfunction

  task automatic check_eq(input string tag, input longint got, input longint exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    writes = 0; bad = 0; done_cnt = 0; max_addr = -1;
  endtask

  // Sprite ROM model, one cycle read latency; mode 1 makes even columns transparent
  always @(posedge clk) begin
    if (rom_mode == 1 && !bus.spr_x[0])
      bus.spr_pixel <= 18'b1;
    else
      bus.spr_pixel <= {enc(int'(bus.spr_x), int'(bus.spr_y), int'(bus.spr_dir)), 2'b00};
  end

  // Frame-buffer write monitor
  always @(negedge clk) begin
    int a, x, y, c, r, sc;
    if (bus.done) done_cnt++;
    if (bus.fb_we) begin
      a = int'(bus.fb_addr);
      x = a % 96;
      y = a / 96;
      c = x - exp_dx;
      r = y - exp_dy;
      sc = (exp_mirror != 0) ? 19 - c : c;
      if (writes == 0) begin
        first_addr = a; first_data = bus.fb_data; first_cyc = cyc;
      end
      last_addr = a;
      last_data = bus.fb_data;
      if (a > max_addr) max_addr = a;
      if (a < 6144) fb_mem[a] = bus.fb_data;
      writes++;
      if (a >= 6144 || c < 0 || c > 19 || r < 0 || r > 19 ||
          (rom_mode == 1 && (sc % 2) == 0) || bus.fb_data != enc(sc, r, exp_dir))
        bad++;
    end
  end

  // Wait a bounded number of cycles for done; returns the cycle index of the done pulse
  task automatic wait_done(input string tag, output int dcyc);
    bit got = 0;
    dcyc = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.done) begin got = 1; dcyc = cyc; break; end
    end
    check_eq({tag, "_done_seen"}, got, 1);
  endtask

  // One complete blit: start, check accept-edge outputs, wait for done
  task automatic run_blit(input string tag, input int dx, input int dy, input int dirv,
                          input int mir, output int e0, output int dcyc);
    @(negedge clk);
    exp_dx = dx; exp_dy = dy; exp_dir = dirv; exp_mirror = mir;
    bus.dst_x = 8'(dx);
    bus.dst_y = 8'(dy);
    bus.dir   = 2'(dirv);
`ifdef BLIT_MIRROR_EN
    bus.mirror = 1'(mir);
`endif
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    clear_stats();
    bus.start = 1'b0;
    check_eq({tag, "_busy_e0"}, bus.busy, 1);
    check_eq({tag, "_spr_x_e0"}, bus.spr_x, (mir != 0) ? 19 : 0);
    check_eq({tag, "_spr_y_e0"}, bus.spr_y, 0);
    check_eq({tag, "_spr_dir"}, bus.spr_dir, dirv);
    wait_done(tag, dcyc);
    check_eq({tag, "_done_latency"}, dcyc - e0, 402);
    check_eq({tag, "_busy_at_done"}, bus.busy, 0);
    repeat (3) @(negedge clk);
    check_eq({tag, "_done_pulses"}, done_cnt, 1);
    check_eq({tag, "_bad_writes"}, bad, 0);
  endtask

  initial begin
    int e0, d1, e0b, d2, snap;
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d1, e0b, d2, snap;
    bus.start = 1'b0;
    bus.dst_x = '0;
    bus.dst_y = '0;
    bus.dir   = '0;
`ifdef BLIT_MIRROR_EN
    bus.mirror = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_fb_we", bus.fb_we, 0);
    check_eq("rst_fb_addr", bus.fb_addr, 0);
    check_eq("rst_fb_data", bus.fb_data, 0);
    check_eq("rst_spr_x", bus.spr_x, 0);
    check_eq("rst_spr_y", bus.spr_y, 0);
    check_eq("rst_spr_dir", bus.spr_dir, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Opaque sprite fully on screen
    rom_mode = 0;
    run_blit("t1", 10, 5, 2, 0, e0, d1);
    check_eq("t1_writes", writes, 400);
    check_eq("t1_first_addr", first_addr, 490);
    check_eq("t1_first_data", first_data, enc(0, 0, 2));
    check_eq("t1_first_latency", first_cyc - e0, 2);
    check_eq("t1_last_addr", last_addr, 2333);
    check_eq("t1_last_data", last_data, enc(19, 19, 2));

    // Clipped on the left and bottom
    run_blit("t2", -5, 50, 1, 0, e0, d1);
    check_eq("t2_writes", writes, 210);
    check_eq("t2_first_addr", first_addr, 4800);
    check_eq("t2_addr_in_range", max_addr < 6144, 1);
    check_eq("t2_max_addr", max_addr, 63 * 96 + 14);

    // Even columns transparent
    rom_mode = 1;
    run_blit("t3", 10, 5, 0, 0, e0, d1);
    check_eq("t3_writes", writes, 200);
    rom_mode = 0;

    // start held through the blit with inputs changing, second start in the done cycle
    @(negedge clk);
    exp_dx = 10; exp_dy = 5; exp_dir = 1; exp_mirror = 0;
    bus.dst_x = 8'd10; bus.dst_y = 8'd5; bus.dir = 2'd1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    clear_stats();
    bus.dst_x = 8'd40; bus.dst_y = 8'd30; bus.dir = 2'd3;
    wait_done("t4a", d1);
    check_eq("t4a_done_latency", d1 - e0, 402);
    check_eq("t4a_writes", writes, 400);
    check_eq("t4a_bad_writes", bad, 0);
    @(posedge clk);
    #1;
    e0b = cyc;
    exp_dx = 40; exp_dy = 30; exp_dir = 3;
    bus.start = 1'b0;
    check_eq("t4b_accept_edge", e0b - d1, 1);
    check_eq("t4b_busy", bus.busy, 1);
    check_eq("t4b_spr_dir", bus.spr_dir, 3);
    wait_done("t4b", d2);
    check_eq("t4b_done_latency", d2 - e0b, 402);
    repeat (3) @(negedge clk);
    check_eq("t4_total_writes", writes, 800);
    check_eq("t4_bad_writes", bad, 0);
    check_eq("t4_done_pulses", done_cnt, 2);

    // Reset mid-blit
    @(negedge clk);
    exp_dx = 10; exp_dy = 5; exp_dir = 2;
    bus.dst_x = 8'd10; bus.dst_y = 8'd5; bus.dir = 2'd2;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    clear_stats();
    bus.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cyc == e0 + 99) break;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t5_busy_after_rst", bus.busy, 0);
    check_eq("t5_fb_we_after_rst", bus.fb_we, 0);
    check_eq("t5_writes_before_rst", writes, 98);
    snap = writes;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (450) @(negedge clk);
    check_eq("t5_no_done", done_cnt, 0);
    check_eq("t5_no_more_writes", writes, snap);
    run_blit("t5r", 10, 5, 2, 0, e0, d1);
    check_eq("t5r_writes", writes, 400);

`ifdef BLIT_MIRROR_EN
    // Horizontal flip at the origin
    run_blit("t6", 0, 0, 1, 1, e0, d1);
    check_eq("t6_writes", writes, 400);
    check_eq("t6_addr0", fb_mem[0], enc(19, 0, 1));
    check_eq("t6_addr19", fb_mem[19], enc(0, 0, 1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
